// File: rtl/seq_shift_add_multplr.sv
// Sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// One add-and-shift iteration per clock; the product register only changes at completion or reset.
module seq_shift_add_multplr #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   // state | meaning
   // IDLE  | waiting for start; product holds the last result
   // CALC  | one add/shift iteration per edge, WIDTH iterations total
   typedef enum logic {IDLE, CALC} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  mcand, mplr, acc;
   logic [CNT_W-1:0]  count;
   logic [WIDTH:0]    sum;
   logic              load, last;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      sum       = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            state_nxt = CALC;
         end
         CALC: if (count == CNT_W'(WIDTH-1)) begin
            last      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_nxt;
   end

   // Add and shift are folded: the carry out of the add becomes the new acc MSB
   // and the sum LSB drops into the multiplier MSB in the same edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mcand   <= '0;
         mplr    <= '0;
         acc     <= '0;
         count   <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= last;
         if (load) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
         end else if (state == CALC) begin
            acc   <= sum[WIDTH:1];
            mplr  <= {sum[0], mplr[WIDTH-1:1]};
            count <= count + 1'b1;
            if (last) product <= {sum[WIDTH:1], sum[0], mplr[WIDTH-1:1]};
         end
      end
   end

   assign busy = (state == CALC);

endmodule

// File: doc/seq_shift_add_multplr.md
Name: seq_shift_add_multplr

Overview:
- Parametrised sequential shift-and-add unsigned multiplier. It replaces the fixed 4-bit combinational multiplier feeding the seven-segment display path.
- Operates on WIDTH-bit operands and uses one adder iteration per clock.
- Uses a start/busy/done handshake.
- Holds the last product in a register so the display driver sees a stable value between operations.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  asynchronous, active-low reset; clr=0 forces reset state immediately.
- start  input  1  request; sampled only while idle.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the product register is updated.
- product  output  2*WIDTH  registered result of the last completed operation.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal accumulator, multiplicand and multiplier registers and counter are all 0.
  - Reset asserted mid-operation aborts the operation. No done pulse is produced and product returns to 0.
- States: IDLE, CALC.
- IDLE:
  - start=1 at edge E0 latches mcand<=a, mplr<=b, acc<=0, carry<=0, count<=0.
  - At the same edge: state<=CALC, busy<=1.
  - start=0 leaves the state unchanged.
- CALC, one iteration per edge:
  - If mplr[0]=1: {carry,acc} <= acc + mcand (WIDTH+1-bit sum); otherwise {carry,acc} <= {0,acc}.
  - Then shift right by one the concatenation {carry, acc, mplr}, filling 0 at the MSB. The bit leaving acc LSB enters mplr MSB.
  - count increments each iteration.
  - The implementation may fold add and shift into a single registered update per edge.
- Completion:
  - On the edge completing iteration WIDTH (edge E0+WIDTH): product <= {acc,mplr} final value; done<=1; busy<=0; state<=IDLE.
  - done deasserts on the following edge unless a new completion occurs (it cannot, because the minimum interval is WIDTH+1 cycles).
- Latency: exactly WIDTH clock cycles from the start-sampling edge to done=1.
- Throughput: the next start is accepted at edge E0+WIDTH+1 at the earliest, i.e. start held high back-to-back gives one result every WIDTH+1 cycles.
- Operand and start handling:
  - start while busy=1 is ignored; there is no queueing and no error flag.
  - a and b changing after capture have no effect on the operation in progress.
- product visibility:
  - product changes only at completion edges and at reset.
  - Intermediate partial products are never visible on product.
- Arithmetic:
  - Unsigned. Result is exact for all inputs; (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Zero operands still take the full WIDTH cycles; there is no early termination.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold clr=0 for 3 cycles with start=1 → busy=0, done=0, product=0 throughout; release → no operation starts until start is sampled with clr=1.
- WIDTH=4: a=4'hF, b=4'hF, start pulse at edge E0 → busy=1 from E0, done=1 only during the cycle after E0+4, product=8'hE1 held until the next completion; a=3, b=5 next → 8'h0F.
- WIDTH=4: a=0, b=4'hB → done at E0+4, product=8'h00. Then a=4'h9, b=1 → product=8'h09. Confirms no early termination.
- WIDTH=8: a=8'hFF, b=8'hFF → product=16'hFE01 at E0+8. Then start held high continuously → completions at 9-cycle intervals; start pulses inside busy are ignored.
- Mid-operation change: after start with a=7, b=6 (WIDTH=4), drive a=F, b=F and pulse start at E0+2 → result 8'h2A, busy timing unchanged.
- Reset mid-op: assert clr=0 at E0+2 of a 4'hC×4'hD operation → busy=0 and product=0 immediately (asynchronous), no done pulse; a new start after release gives 8'h9C.
